// File: rtl/memory_if.sv
// Request/response bus between a page-table walker (master) and the
// read-only backing memory (slave). Names carry the memory-side direction.
interface memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid_i;
  logic                  mem_req_ready_o;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic                  mem_resp_valid_o;
  logic                  mem_resp_ready_i;
  logic [DATA_WIDTH-1:0] mem_data_o;

  modport master (
    output mem_req_valid_i,
    output mem_addr_i,
    output mem_resp_ready_i,
    input  mem_req_ready_o,
    input  mem_resp_valid_o,
    input  mem_data_o
  );

  modport slave (
    input  mem_req_valid_i,
    input  mem_addr_i,
    input  mem_resp_ready_i,
    output mem_req_ready_o,
    output mem_resp_valid_o,
    output mem_data_o
  );
endinterface

// File: rtl/memory.sv
// Read-only, word-addressed backing memory for page-table walks.
// One outstanding request; valid/ready request and response channels.
// 4 KiB image: root page table at 0x400, second-level table at 0x800.
// Optional simulation trace of both handshakes: define MEMORY_TRACE_EN.
module memory #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  memory_if.slave    bus
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int BYTE_W  = IDX_W + 2;
  localparam int CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_READ_ACCESS = 2'b01,
    ST_RESPOND     = 2'b10
  } state_e;

  // Fixed image contents; every word not listed reads as zero.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] word;
    case (idx)
      IDX_W'(32'h100): word = DATA_WIDTH'(32'h0000_0801); // 0x400 root entry -> L2 table
      IDX_W'(32'h101): word = DATA_WIDTH'(32'h1234_0007); // 0x404
      IDX_W'(32'h200): word = DATA_WIDTH'(32'h1000_000F); // 0x800
      IDX_W'(32'h201): word = DATA_WIDTH'(32'h1100_000F); // 0x804
      IDX_W'(32'h202): word = DATA_WIDTH'(32'h1200_0007); // 0x808
      default:         word = {DATA_WIDTH{1'b0}};
    endcase
    return word;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  oob_q, oob_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;

  // Byte-offset bits are deliberately ignored: misaligned reads round down.
  logic unused_addr_s;
  assign unused_addr_s = ^bus.mem_addr_i[1:0];

  // State and output registers; reset aborts any access, storage is constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      idx_q        <= {IDX_W{1'b0}};
      oob_q        <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      oob_q        <= oob_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state logic: accept in IDLE, count latency, hold response until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oob_d   = oob_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req_valid_i && ready_q) begin
          state_d = ST_READ_ACCESS;
          cnt_d   = CNT_LOAD;
          idx_d   = bus.mem_addr_i[BYTE_W-1:2];
          oob_d   = |bus.mem_addr_i[ADDR_WIDTH-1:BYTE_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ_ACCESS: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RESPOND;
          if (oob_q) begin
            data_d = {DATA_WIDTH{1'b0}};
          end else begin
            data_d = rom_word(idx_q);
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESPOND: begin
        if (bus.mem_resp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESPOND;
        end
      end
      default: begin
        // Unused encoding 2'b11 falls back to IDLE.
        state_d = ST_IDLE;
      end
    endcase
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESPOND);
  end

  assign bus.mem_req_ready_o  = ready_q;
  assign bus.mem_resp_valid_o = resp_valid_q;
  assign bus.mem_data_o       = data_q;

`ifdef MEMORY_TRACE_EN
  // Simulation trace of request and response handshakes.
  always @(posedge clk) begin
    if (!rst && bus.mem_req_valid_i && ready_q) begin
      $display("[%0t] memory req  addr=0x%08h idx=%0d", $time, bus.mem_addr_i,
               bus.mem_addr_i[BYTE_W-1:2]);
    end
    if (!rst && resp_valid_q && bus.mem_resp_ready_i) begin
      $display("[%0t] memory resp data=0x%08h", $time, data_q);
    end
  end
`else
  // Trace disabled: no additional logic.
`endif

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed and randomized reads compared
// against an address-level model of the preloaded page-table image.
module tb_memory;

  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycles     = 0;

  logic [31:0] image [logic [31:0]];

  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  memory #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (1024),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference: 4 KiB byte space, words addressed by rounding down, zero elsewhere.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] wa;
    if (a >= 32'h0000_1000) return 32'h0;
    wa = a & 32'hFFFF_FFFC;
    if (image.exists(wa)) return image[wa];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One read transaction; delay = cycles resp_ready is withheld,
  // hold = keep req_valid one extra cycle past the handshake.
  task automatic do_read(input logic [31:0] a, input int delay, input bit hold);
    logic [31:0] exp;
    int lat;
    int guard;
    exp = ref_read(a);
    guard = 0;
    while (bus.mem_req_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", {31'b0, bus.mem_req_ready_o}, 32'h1);
    bus.mem_req_valid_i = 1'b1;
    bus.mem_addr_i      = a;
    @(negedge clk);
    lat = 1;
    if (hold) begin
      @(negedge clk);
      lat++;
    end
    bus.mem_req_valid_i = 1'b0;
    while (bus.mem_resp_valid_o !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(1 + RL));
    check("resp_data", bus.mem_data_o, exp);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_valid", {31'b0, bus.mem_resp_valid_o}, 32'h1);
      check("wait_data", bus.mem_data_o, exp);
    end
    bus.mem_resp_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_resp_ready_i = 1'b0;
    check("post_resp_valid", {31'b0, bus.mem_resp_valid_o}, 32'h0);
    check("post_resp_data", bus.mem_data_o, exp);
  endtask

  initial begin
    logic [31:0] directed [15];
    logic [31:0] stress [10];
    logic [31:0] table_addr [5];
    logic [31:0] a;
    int start;

    image[32'h400] = 32'h0000_0801;
    image[32'h404] = 32'h1234_0007;
    image[32'h800] = 32'h1000_000F;
    image[32'h804] = 32'h1100_000F;
    image[32'h808] = 32'h1200_0007;

    directed = '{32'h000, 32'h004, 32'h100, 32'h408, 32'h80C,
                 32'h400, 32'h404, 32'h800, 32'h804, 32'h808,
                 32'h1000, 32'h10000, 32'hFFC, 32'h403, 32'h806};
    stress   = '{32'h000, 32'h400, 32'h404, 32'h408, 32'h800,
                 32'h804, 32'h808, 32'h80C, 32'hFFC, 32'h1000};
    table_addr = '{32'h400, 32'h404, 32'h800, 32'h804, 32'h808};

    rst = 1'b1;
    bus.mem_req_valid_i  = 1'b0;
    bus.mem_addr_i       = 32'h0;
    bus.mem_resp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, bus.mem_req_ready_o}, 32'h1);
    check("reset_resp_valid", {31'b0, bus.mem_resp_valid_o}, 32'h0);
    check("reset_data", bus.mem_data_o, 32'h0);

    foreach (directed[i]) do_read(directed[i], 0, 1'b0);

    // Held request valid plus delayed consumer: exactly one response.
    do_read(32'h404, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_resp", {31'b0, bus.mem_resp_valid_o}, 32'h0);
      check("idle_ready", {31'b0, bus.mem_req_ready_o}, 32'h1);
      check("data_retained", bus.mem_data_o, 32'h1234_0007);
    end

    // Reset during READ_ACCESS aborts the read.
    bus.mem_req_valid_i = 1'b1;
    bus.mem_addr_i      = 32'h800;
    @(negedge clk);
    bus.mem_req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_resp", {31'b0, bus.mem_resp_valid_o}, 32'h0);
      check("abort_data", bus.mem_data_o, 32'h0);
    end
    check("abort_ready", {31'b0, bus.mem_req_ready_o}, 32'h1);

    // Randomized reads across the image, the zero region and out of range.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = table_addr[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
        1:       a = $urandom & 32'h0000_0FFF;
        2:       a = $urandom | 32'h0000_1000;
        default: a = 32'h400 + 32'($urandom_range(0, 32'h40F));
      endcase
      do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Back-to-back stress with a cycle budget.
    start = cycles;
    foreach (stress[i]) do_read(stress[i], 0, 1'b0);
    check("stress_budget", {31'b0, (cycles - start) < 5000}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
